// File: rtl/lifo_pop_serializer.sv
// lifo_pop_serializer
//   Drain stage for the LIFO buffer. On start it pops words one at a time and
//   shifts each out MSB first on a 1-bit serial line with a framing enable,
//   until the LIFO reports empty or MAX_WORDS words have been sent.
//
// Optional feature: define LIFO_SER_PARITY_EN to append an even-parity bit
//   to every word (frame = DATA_W+1 bits). Undefined: frame = DATA_W bits.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high
//   start      in   drain request, sampled in IDLE only
//   lifo_data  in   LIFO dataout, valid one cycle after lifo_read
//   lifo_val   in   1 = popped word valid, 0 = LIFO was empty
//   lifo_read  out  one-cycle pop strobe
//   sout       out  serial data, MSB first
//   sout_en    out  high while sout carries a data or parity bit
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse when a burst ends
//   word_cnt   out  words sent in current/last burst, saturating
module lifo_pop_serializer #(
    parameter int unsigned DATA_W    = 10,
    parameter int unsigned MAX_WORDS = 6,
    parameter int unsigned CNT_W     = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] lifo_data,
    input  logic              lifo_val,
    output logic              lifo_read,
    output logic              sout,
    output logic              sout_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_WAIT   = 3'd2,
        S_SHIFT  = 3'd3,
        S_PARITY = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   shreg_q;
    logic [DATA_W-1:0]   shreg_d;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [BIT_W-1:0]    bit_cnt_d;
    logic                parity_q;
    logic                parity_d;
    logic [CNT_W-1:0]    word_cnt_d;
    logic [CNT_W-1:0]    cnt_inc;
    logic                last_word;
    logic                lifo_read_d;
    logic                sout_d;
    logic                sout_en_d;
    logic                busy_d;
    logic                done_d;

    // Saturating count of words including the one just completed
    assign cnt_inc   = (word_cnt == {CNT_W{1'b1}}) ? word_cnt : word_cnt + CNT_W'(1);
    assign last_word = (MAX_WORDS != 0) && (cnt_inc == CNT_W'(MAX_WORDS));

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_POP;
            S_POP:    state_d = S_WAIT;
            S_WAIT:   state_d = lifo_val ? S_SHIFT : S_FINISH;
            S_SHIFT: begin
                if (bit_cnt_q == '0) begin
`ifdef LIFO_SER_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = last_word ? S_FINISH : S_POP;
`endif
                end
            end
`ifdef LIFO_SER_PARITY_EN
            S_PARITY: state_d = last_word ? S_FINISH : S_POP;
`endif
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and next values of the registered outputs
    always_comb begin
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        parity_d    = parity_q;
        word_cnt_d  = word_cnt;
        lifo_read_d = 1'b0;
        sout_d      = 1'b0;
        sout_en_d   = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) word_cnt_d = '0;
            end
            S_WAIT: begin
                if (lifo_val) begin
                    shreg_d   = lifo_data;
                    bit_cnt_d = BIT_W'(DATA_W - 1);
                    parity_d  = ^lifo_data;
                end
            end
            S_SHIFT: begin
                // After DATA_W shifts the register has drained to zero
                shreg_d = shreg_q << 1;
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - BIT_W'(1);
                end else begin
`ifndef LIFO_SER_PARITY_EN
                    word_cnt_d = cnt_inc;
`endif
                end
            end
`ifdef LIFO_SER_PARITY_EN
            S_PARITY: word_cnt_d = cnt_inc;
`endif
            default: ;
        endcase

        // Outputs follow the state being entered so they are registered
        lifo_read_d = (state_d == S_POP);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FINISH);
        if (state_d == S_SHIFT) begin
            sout_d    = shreg_d[DATA_W-1];
            sout_en_d = 1'b1;
        end else if (state_d == S_PARITY) begin
            sout_d    = parity_d;
            sout_en_d = 1'b1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            word_cnt  <= '0;
            lifo_read <= 1'b0;
            sout      <= 1'b0;
            sout_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            word_cnt  <= word_cnt_d;
            lifo_read <= lifo_read_d;
            sout      <= sout_d;
            sout_en   <= sout_en_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_lifo_pop_serializer.sv
// Scoreboard bench for lifo_pop_serializer with a behavioural LIFO model.
module tb_lifo_pop_serializer;

    localparam int unsigned DATA_W    = 10;
    localparam int unsigned MAX_WORDS = 3;
    localparam int unsigned CNT_W     = 4;
`ifdef LIFO_SER_PARITY_EN
    localparam int unsigned FRAME = DATA_W + 1;
`else
    localparam int unsigned FRAME = DATA_W;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [DATA_W-1:0] lifo_data = '0;
    logic              lifo_val = 1'b0;
    logic              lifo_read;
    logic              sout;
    logic              sout_en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  word_cnt;

    int          checks = 0;
    int          errors = 0;
    int          rd_pulses = 0;
    int          en_cycles = 0;
    bit          exp_bits[$];
    int unsigned exp_cnt[$];
    int unsigned stack[$];

    lifo_pop_serializer #(
        .DATA_W   (DATA_W),
        .MAX_WORDS(MAX_WORDS),
        .CNT_W    (CNT_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .lifo_data(lifo_data),
        .lifo_val (lifo_val),
        .lifo_read(lifo_read),
        .sout     (sout),
        .sout_en  (sout_en),
        .busy     (busy),
        .done     (done),
        .word_cnt (word_cnt)
    );

    always #5 clock = ~clock;

    // LIFO read port: registered dataout/val, one cycle after the pop strobe
    always @(posedge clock) begin
        if (lifo_read) begin
            if (stack.size() > 0) begin
                lifo_data <= DATA_W'(stack.pop_back());
                lifo_val  <= 1'b1;
            end else begin
                lifo_val  <= 1'b0;
            end
        end
    end

    function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: serial bits and done pulses checked against the scoreboard
    always @(negedge clock) begin
        if (!reset) begin
            chk("read_while_idle", 32'(lifo_read && !busy), 0);
            if (lifo_read) rd_pulses++;
            if (sout_en) begin
                en_cycles++;
                if (exp_bits.size() == 0) begin
                    chk("unexpected_bit", 1, 0);
                end else begin
                    chk("sout_bit", 32'(sout), 32'(exp_bits.pop_front()));
                end
            end else if (sout) begin
                chk("sout_idle_low", 32'(sout), 0);
            end
            if (done) begin
                if (exp_cnt.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("done_word_cnt", 32'(word_cnt), exp_cnt.pop_front());
                end
            end
        end
    end

    task automatic exp_word(input logic [DATA_W-1:0] w, input bit p);
        for (int i = DATA_W - 1; i >= 0; i--) exp_bits.push_back(w[i]);
`ifdef LIFO_SER_PARITY_EN
        exp_bits.push_back(p);
`else
        if (p) begin end
`endif
    endtask

    task automatic start_pulse();
        @(negedge clock);
        rd_pulses = 0;
        en_cycles = 0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {27'd0, lifo_read, sout, sout_en, busy, done}, 0);
        chk({name, "_cnt"}, 32'(word_cnt), 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        chk_all_zero("reset");
        reset = 1'b0;

        // Two words, then LIFO empty: 3 pops, word_cnt=2
        stack = '{10'h2A5, 10'h155};
        exp_word(10'h155, 1'b1);
        exp_word(10'h2A5, 1'b1);
        exp_cnt.push_back(2);
        start_pulse();
        wait_done(100);
        chk("t2_reads", 32'(rd_pulses), 3);
        chk("t2_frame_bits", 32'(en_cycles), 2 * FRAME);
        @(negedge clock);
        chk("t2_idle", 32'(busy), 0);

        // Empty LIFO: read at cycle 1, done at cycle 3, no data bits
        exp_cnt.push_back(0);
        @(negedge clock);
        en_cycles = 0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("t3_read_c1", 32'(lifo_read), 1);
        chk("t3_busy_c1", 32'(busy), 1);
        @(negedge clock);
        chk("t3_read_c2", 32'(lifo_read), 0);
        chk("t3_done_c2", 32'(done), 0);
        @(negedge clock);
        chk("t3_done_c3", 32'(done), 1);
        chk("t3_cnt", 32'(word_cnt), 0);
        @(negedge clock);
        chk("t3_done_c4", 32'(done), 0);
        chk("t3_busy_c4", 32'(busy), 0);
        chk("t3_no_bits", 32'(en_cycles), 0);

        // Five words, MAX_WORDS=3: three sent, two remain
        stack = '{10'h001, 10'h002, 10'h003, 10'h3FF, 10'h200};
        exp_word(10'h200, 1'b1);
        exp_word(10'h3FF, 1'b0);
        exp_word(10'h003, 1'b0);
        exp_cnt.push_back(3);
        start_pulse();
        wait_done(150);
        chk("t4_reads", 32'(rd_pulses), 3);
        chk("t4_remaining", 32'(stack.size()), 2);
        // Drain the remainder
        exp_word(10'h002, 1'b1);
        exp_word(10'h001, 1'b1);
        exp_cnt.push_back(2);
        start_pulse();
        wait_done(150);
        chk("t4b_reads", 32'(rd_pulses), 3);
        chk("t4b_remaining", 32'(stack.size()), 0);

        // start held high for the whole burst: exactly one burst
        stack = '{10'h0F0};
        exp_word(10'h0F0, 1'b0);
        exp_cnt.push_back(1);
        @(negedge clock);
        rd_pulses = 0;
        start = 1'b1;
        wait_done(100);
        start = 1'b0;
        repeat (4) @(negedge clock);
        chk("t5_reads", 32'(rd_pulses), 2);
        chk("t5_idle", 32'(busy), 0);

        // Word 0x007: frame length (parity bit 1 when enabled)
        stack = '{10'h007};
        exp_word(10'h007, 1'b1);
        exp_cnt.push_back(1);
        start_pulse();
        wait_done(100);
        chk("t6_frame_bits", 32'(en_cycles), FRAME);
        chk("t6_reads", 32'(rd_pulses), 2);

        // Reset after 4 bits of a word aborts with no done
        stack = '{10'h3FF};
        repeat (4) exp_bits.push_back(1'b1);
        start_pulse();
        for (int i = 0; i < 10 && !sout_en; i++) @(negedge clock);
        chk("t1_first_bit", 32'(sout_en), 1);
        repeat (3) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("t1_async");
        @(negedge clock);
        chk_all_zero("t1_next");
        reset = 1'b0;
        stack.delete();
        repeat (3) @(negedge clock);
        chk("t1_idle", 32'(busy), 0);
        chk("t1_bits_left", 32'(exp_bits.size()), 0);

        chk("sb_bits_empty", 32'(exp_bits.size()), 0);
        chk("sb_done_empty", 32'(exp_cnt.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
